mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative RV32M multiply/divide unit that sits directly downstream of register_file.
- Consumes the two read-port operands (rd1_o/rd2_o) plus the destination address.
- Produces a write-back triple (we, address, data) that drives the register file's we_i/wd_addr_i/wd_i.
- Fixed 34-cycle latency, one operation in flight, radix-2 shift-add multiply and restoring divide.

Parameters:
WIDTH, 32, operand/result width (only 32 is supported; the parameter exists for constants and counter sizing).

Ports:
clk_i  input  1  clock, all state on rising edge
reset_i  input  1  synchronous, active-high reset
start_i  input  1  request; accepted only in IDLE
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_i  input  32  operand A (from rd1_o)
rs2_i  input  32  operand B (from rd2_o)
rd_addr_i  input  5  destination register
busy_o  input/output: output  1  high in every state except IDLE; used by the pipeline as a stall
we_o  output  1  one-cycle write-back strobe
wd_addr_o  output  5  destination register, latched at accept
wd_o  output  32  result, valid while we_o=1

Behaviour:
- Reset (sync, reset_i=1 at an edge):
  - State goes to IDLE.
  - busy_o=0, we_o=0, wd_addr_o=0, wd_o=0.
  - Any in-flight operation is discarded; no we_o is produced for it.
  - Reset has priority over start_i.
- FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - start_i=1 at edge N latches op, rd_addr, and the operands.
  - Latches operand magnitudes and sign flags, clears the 6-bit iteration counter, then moves to CALC.
  - start_i=0 keeps the unit in IDLE.
- CALC: 32 iterations, one per edge (edges N+1..N+32); the counter wraps 31->0 on the transition to FIX.
  - Multiply: 64-bit accumulator; the multiplier is shifted right, and the multiplicand is added to the upper half when the LSB is 1.
  - Divide: restoring; remainder = {rem[30:0], dividend MSB}; subtract divisor if no borrow; quotient bit = !borrow.
- FIX (edge N+33): sign correction and special cases, result registered into wd_o, then moves to DONE.
  - MUL: low 32 bits; MULH/MULHSU/MULHU: high 32 bits.
  - Signedness: MULH treats both operands as signed; MULHSU treats rs1 as signed, rs2 as unsigned; MULHU treats both as unsigned.
  - Product negated (64-bit two's complement) when the result sign is 1.
  - DIV/REM: quotient sign = s1^s2, remainder sign = s1; DIVU/REMU are unsigned.
  - Divide by zero (rs2=0): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM only): DIV -> 0x80000000, REM -> 0.
  - Special cases still take the full latency (fixed latency, no early-out).
- DONE: we_o=1 for exactly this one cycle, with wd_addr_o/wd_o stable; next edge returns to IDLE and we_o drops to 0.
- Latency: start accepted at edge N -> we_o high during the cycle after edge N+33 (34 cycles).
- Throughput: next start is accepted at the earliest in the IDLE cycle after DONE.
- start_i while busy_o=1 is ignored, with no queuing and no effect on the current operation.
- rd_addr_i=0: computed normally and we_o still pulses; the register file discards writes to x0.
- wd_o and wd_addr_o hold their last values after DONE until the next FIX/accept; only we_o qualifies them.
- Operands are sampled only at accept; later changes on rs1_i/rs2_i have no effect.

Decomposition:
- Shared package mdu_pkg:
  - op encodings (MDU_MUL..MDU_REMU, 3 bits)
  - state enum (IDLE, CALC, FIX, DONE)
  - constant ITER = 32
  - constants DIV0_Q = 32'hFFFF_FFFF and OVF_Q = 32'h8000_0000
- Single module; no sub-module is needed. The datapath is one shared 64-bit accumulator plus a 33-bit subtractor.

Test Plan:
- MUL: rs1=7, rs2=0xFFFFFFFD -> wd_o=0xFFFFFFEB, we_o exactly 34 cycles after start, one cycle wide.
- High-half multiplies:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV/REM signed: rs1=0xFFFFFFF9 (-7), rs2=2 -> DIV=0xFFFFFFFD, REM=0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; both at full 34-cycle latency.
- Back-to-back:
  - start_i held high continuously -> second operation accepted only in the IDLE cycle after DONE.
  - Pulses on start_i during busy change neither the result nor wd_addr_o.
- Reset mid-operation: reset_i=1 at cycle 10 of CALC -> busy_o=0 and wd_o=0 after that edge, no we_o ever produced, next start runs cleanly with correct result.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM states, iteration count, special-case results,
// and small sign-correction helpers.
package mdu_pkg;

  // funct3 encodings of the M-extension operations
  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

  // One shift/add or shift/subtract step per bit of the operands
  localparam int ITER = 32;

  // Quotient returned on divide-by-zero and on signed overflow
  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q  = 32'h8000_0000;

  // Two's-complement negate when neg is set (magnitude <-> signed value)
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // 64-bit variant used for the full product
  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit with fixed 34-cycle latency.
// Operands are converted to magnitudes at accept, a shared 64-bit
// accumulator runs 32 shift-add (multiply) or restoring-divide steps,
// and the sign/special-case correction happens in a single FIX cycle.
// The result is presented as a one-cycle register-file write-back.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic [4:0]       rd_addr_i,
  output logic             busy_o,
  output logic             we_o,
  output logic [4:0]       wd_addr_o,
  output logic [WIDTH-1:0] wd_o
);
  import mdu_pkg::*;

  localparam int         W         = WIDTH;
  localparam logic [5:0] LAST_ITER = 6'(ITER - 1);

  // FSM
  mdu_state_e     r_state;
  mdu_state_e     w_next_state;

  // Latched operation context
  logic [2:0]     r_op;
  logic [2*W-1:0] r_acc;      // {upper/remainder, lower/multiplier-or-quotient}
  logic [W-1:0]   r_mcand;    // multiplicand magnitude or divisor magnitude
  logic [W-1:0]   r_rs1;      // raw rs1, returned by REM/REMU on divide-by-zero
  logic [5:0]     r_cnt;
  logic           r_neg_q;    // product / quotient sign
  logic           r_neg_r;    // remainder sign
  logic           r_div0;
  logic           r_ovf;

  // Registered outputs
  logic           r_busy;
  logic           r_we;
  logic [4:0]     r_wd_addr;
  logic [W-1:0]   r_wd;

  // Combinational datapath
  logic           w_accept;
  logic           w_sgn1_en;
  logic           w_sgn2_en;
  logic           w_s1;
  logic           w_s2;
  logic           w_ovf;
  logic [W-1:0]   w_mag1;
  logic [W-1:0]   w_mag2;
  logic [W:0]     w_sum;
  logic [W:0]     w_trial;
  logic [W-1:0]   w_diff;
  logic           w_borrow;
  logic [2*W-1:0] w_mul_next;
  logic [2*W-1:0] w_div_next;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;
  logic [W-1:0]   w_result;
  logic           w_busy_nxt;
  logic           w_we_nxt;

  assign w_accept = (r_state == IDLE) && start_i;

  // Decode which operands are interpreted as signed for the incoming op
  always_comb begin
    w_sgn1_en = 1'b0;
    w_sgn2_en = 1'b0;
    case (mdu_op_e'(op_i))
      MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: begin
        w_sgn1_en = 1'b1;
        w_sgn2_en = 1'b1;
      end
      MDU_MULHSU: begin
        w_sgn1_en = 1'b1;
        w_sgn2_en = 1'b0;
      end
      default: begin
        w_sgn1_en = 1'b0;
        w_sgn2_en = 1'b0;
      end
    endcase
  end

  assign w_s1   = w_sgn1_en & rs1_i[W-1];
  assign w_s2   = w_sgn2_en & rs2_i[W-1];
  assign w_mag1 = cond_neg32(rs1_i, w_s1);
  assign w_mag2 = cond_neg32(rs2_i, w_s2);
  // Only the signed divides (DIV/REM) can overflow
  assign w_ovf  = w_sgn1_en & op_i[2] & (rs1_i == OVF_Q) & (rs2_i == {W{1'b1}});

  // One multiply step: conditionally add multiplicand to upper half, shift right
  always_comb begin
    if (r_acc[0]) begin
      w_sum = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_mcand};
    end else begin
      w_sum = {1'b0, r_acc[2*W-1:W]};
    end
    w_mul_next = {w_sum, r_acc[W-1:1]};
  end

  // One restoring-divide step: shift in dividend MSB, trial-subtract divisor.
  // The trial remainder is 33 bits so divisors above 2^31 work for DIVU/REMU.
  always_comb begin
    w_trial  = {r_acc[2*W-1:W], r_acc[W-1]};
    w_borrow = (w_trial < {1'b0, r_mcand});
    w_diff   = w_trial[W-1:0] - r_mcand;
    if (w_borrow) begin
      w_div_next = {w_trial[W-1:0], r_acc[W-2:0], 1'b0};
    end else begin
      w_div_next = {w_diff, r_acc[W-2:0], 1'b1};
    end
  end

  // Sign correction and special-case selection for the FIX cycle
  always_comb begin
    w_prod   = cond_neg64(r_acc, r_neg_q);
    w_quo    = cond_neg32(r_acc[W-1:0], r_neg_q);
    w_rem    = cond_neg32(r_acc[2*W-1:W], r_neg_r);
    w_result = {W{1'b0}};
    case (mdu_op_e'(r_op))
      MDU_MUL: begin
        w_result = w_prod[W-1:0];
      end
      MDU_MULH, MDU_MULHSU, MDU_MULHU: begin
        w_result = w_prod[2*W-1:W];
      end
      MDU_DIV, MDU_DIVU: begin
        if (r_div0) begin
          w_result = DIV0_Q;
        end else if (r_ovf) begin
          w_result = OVF_Q;
        end else begin
          w_result = w_quo;
        end
      end
      MDU_REM, MDU_REMU: begin
        if (r_div0) begin
          w_result = r_rs1;
        end else if (r_ovf) begin
          w_result = {W{1'b0}};
        end else begin
          w_result = w_rem;
        end
      end
      default: begin
        w_result = {W{1'b0}};
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; special cases still run all iterations
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_next_state = CALC;
        end else begin
          w_next_state = IDLE;
        end
      end
      CALC: begin
        if (r_cnt == LAST_ITER) begin
          w_next_state = FIX;
        end else begin
          w_next_state = CALC;
        end
      end
      FIX:     w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM output decode, registered below so outputs come straight from flops
  always_comb begin
    w_busy_nxt = (w_next_state != IDLE);
    w_we_nxt   = (w_next_state == DONE);
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_op    <= 3'b000;
      r_acc   <= {(2*W){1'b0}};
      r_mcand <= {W{1'b0}};
      r_rs1   <= {W{1'b0}};
      r_cnt   <= 6'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_op    <= op_i;
            r_rs1   <= rs1_i;
            r_cnt   <= 6'd0;
            r_neg_q <= w_s1 ^ w_s2;
            r_neg_r <= w_s1;
            r_div0  <= (rs2_i == {W{1'b0}});
            r_ovf   <= w_ovf;
            if (op_i[2]) begin
              r_mcand <= w_mag2;
              r_acc   <= {{W{1'b0}}, w_mag1};
            end else begin
              r_mcand <= w_mag1;
              r_acc   <= {{W{1'b0}}, w_mag2};
            end
          end
        end
        CALC: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          r_cnt <= (r_cnt == LAST_ITER) ? 6'd0 : (r_cnt + 6'd1);
        end
        default: begin
        end
      endcase
    end
  end

  // Output registers: busy/we follow the next state, address at accept, data at FIX
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_busy    <= 1'b0;
      r_we      <= 1'b0;
      r_wd_addr <= 5'd0;
      r_wd      <= {W{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
      r_we   <= w_we_nxt;
      if (w_accept) begin
        r_wd_addr <= rd_addr_i;
      end
      if (r_state == FIX) begin
        r_wd <= w_result;
      end
    end
  end

  assign busy_o    = r_busy;
  assign we_o      = r_we;
  assign wd_addr_o = r_wd_addr;
  assign wd_o      = r_wd;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit with hand-computed expected results.
module tb_mul_div_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o;
  logic        we_o;
  logic [4:0]  wd_addr_o;
  logic [31:0] wd_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Edges after the accept edge at which we_o is first seen high
  localparam int LAT_EDGES = 33;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .rd_addr_i (rd_addr_i),
    .busy_o    (busy_o),
    .we_o      (we_o),
    .wd_addr_o (wd_addr_o),
    .wd_o      (wd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble the inputs after accept, optionally pulse
  // start_i while busy, then check latency, result, address and strobe width.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input logic pulse);
    int          lat;
    logic        seen;
    logic [31:0] got_d;
    logic [4:0]  got_a;
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_addr_i = rd;
    @(posedge clk_i); #1;
    start_i = 1'b0; op_i = ~op; rs1_i = 32'h5A5A_1234; rs2_i = 32'h0000_0003; rd_addr_i = ~rd;
    lat = 0; seen = 1'b0; got_d = 32'd0; got_a = 5'd0;
    while (!seen && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
      if (we_o) begin
        seen  = 1'b1;
        got_d = wd_o;
        got_a = wd_addr_o;
      end
      start_i = (pulse && (lat == 5 || lat == 20)) ? 1'b1 : 1'b0;
    end
    start_i = 1'b0;
    check_eq({tag, " latency"}, 32'(lat), 32'(LAT_EDGES));
    check_eq({tag, " wd"}, got_d, exp);
    check_eq({tag, " wd_addr"}, {27'd0, got_a}, {27'd0, rd});
    @(posedge clk_i); #1;
    check_eq({tag, " we_drop"}, {31'd0, we_o}, 32'd0);
    check_eq({tag, " busy_drop"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int first;
    int second;
    int we_cnt;
    logic busy_gap;
    logic [31:0] second_d;

    reset_i = 1'b1; start_i = 1'b0; op_i = 3'd0; rs1_i = 32'd0; rs2_i = 32'd0; rd_addr_i = 5'd0;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("reset busy", {31'd0, busy_o}, 32'd0);
    check_eq("reset we", {31'd0, we_o}, 32'd0);
    check_eq("reset wd_addr", {27'd0, wd_addr_o}, 32'd0);
    check_eq("reset wd", wd_o, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;

    run_op("MUL",    3'b000, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1'b0);
    run_op("MULH",   3'b001, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, 1'b0);
    run_op("MULHU",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1'b0);
    run_op("MULHSU", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 1'b0);
    run_op("DIV",    3'b100, 32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFD, 1'b0);
    run_op("REM",    3'b110, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 1'b0);
    run_op("DIVU",   3'b101, 32'd100,        32'd7,         5'd7,  32'd14,        1'b0);
    run_op("REMU",   3'b111, 32'd100,        32'd7,         5'd8,  32'd2,         1'b0);
    run_op("DIVU0",  3'b101, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1'b0);
    run_op("REM0",   3'b110, 32'd5,          32'd0,         5'd10, 32'd5,         1'b0);
    run_op("DIVOVF", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b0);
    run_op("REMOVF", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1'b0);
    run_op("DIVU_BIG", 3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 5'd13, 32'd1,        1'b0);
    run_op("REMU_BIG", 3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 5'd14, 32'h7FFF_FFFE, 1'b0);
    run_op("X0",     3'b000, 32'd6,          32'd7,         5'd0,  32'd42,        1'b0);
    // start pulses while busy must not disturb the result or address
    run_op("PULSE",  3'b101, 32'd100,        32'd7,         5'd5,  32'd14,        1'b1);

    // start_i held high: second op accepted in the IDLE cycle after DONE
    @(negedge clk_i);
    start_i = 1'b1; op_i = 3'b000; rs1_i = 32'd3; rs2_i = 32'd4; rd_addr_i = 5'd3;
    @(posedge clk_i); #1;
    cnt = 0; first = 0; second = 0; busy_gap = 1'b1; second_d = 32'd0;
    while (second == 0 && cnt < 200) begin
      @(posedge clk_i); #1;
      cnt++;
      if (cnt == LAT_EDGES + 1) busy_gap = busy_o;
      if (we_o) begin
        if (first == 0) begin
          first = cnt;
        end else begin
          second   = cnt;
          second_d = wd_o;
          start_i  = 1'b0;
        end
      end
    end
    start_i = 1'b0;
    check_eq("B2B first", 32'(first), 32'(LAT_EDGES));
    check_eq("B2B idle gap busy", {31'd0, busy_gap}, 32'd0);
    check_eq("B2B second", 32'(second), 32'(2 * LAT_EDGES + 2));
    check_eq("B2B second wd", second_d, 32'd12);
    repeat (3) @(posedge clk_i);

    // Reset in the middle of CALC discards the operation
    @(negedge clk_i);
    start_i = 1'b1; op_i = 3'b011; rs1_i = 32'h1234_5678; rs2_i = 32'h9ABC_DEF0; rd_addr_i = 5'd17;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("RST busy", {31'd0, busy_o}, 32'd0);
    check_eq("RST wd", wd_o, 32'd0);
    check_eq("RST wd_addr", {27'd0, wd_addr_o}, 32'd0);
    check_eq("RST we", {31'd0, we_o}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_i); #1;
      if (we_o) we_cnt++;
    end
    check_eq("RST no we", 32'(we_cnt), 32'd0);
    run_op("POSTRST", 3'b100, 32'd100, 32'hFFFF_FFF9, 5'd21, 32'hFFFF_FFF2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
